// File: rtl/mult_display_ctrl.sv
// mult_display_ctrl
//
// Accepts a pair of 4-bit unsigned operands and multiplies them by serial
// shift-add, one multiplier bit per cycle (4 cycles). The product is then
// converted to three BCD digits by double dabble (8 cycles). The result is
// shown on a multiplexed 3-digit, 7-segment display. A free-running refresh
// counter rotates the enabled digit units -> tens -> hunds.
//
// Parameter
//   REFRESH_DIV  clock cycles each digit is driven during scan (2..2^20)
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      operand pair offered; transfer when i_valid && o_ready
//   i_a, i_b     4-bit unsigned operands
//   o_ready      operand pair can be accepted (IDLE, SHOW)
//   o_busy       multiply/convert in progress (MUL, BCD)
//   o_done       one-cycle pulse on entry to SHOW
//   o_result     latched 8-bit product
//   o_seg        active-high segments {g,f,e,d,c,b,a} of the enabled digit
//   o_digit_en   one-hot digit enable {hunds, tens, units}
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, a zero hunds digit is blanked, and the
//                          tens digit is blanked when both tens and hunds are
//                          zero. Units is never blanked.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for the first operand pair
// MUL   | shift-add multiply, 4 cycles
// BCD   | double-dabble binary to BCD, 8 cycles
// SHOW  | result latched and displayed, waiting for the next operand pair

module mult_display_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic [6:0] o_seg,
    output logic [2:0] o_digit_en
);

    localparam int unsigned     CNT_W  = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] REF_TC = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_BCD  = 2'd2,
        ST_SHOW = 2'd3
    } state_t;

    function automatic logic [3:0] add3_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    state_t            state_q,  state_d;
    logic [2:0]        step_q,   step_d;
    logic [7:0]        mcand_q,  mcand_d;
    logic [3:0]        mplier_q, mplier_d;
    logic [7:0]        prod_q,   prod_d;
    // {hunds, tens, units, binary} shift register for double dabble
    logic [19:0]       bcd_q,    bcd_d;
    logic [7:0]        result_q, result_d;
    logic [3:0]        units_q,  units_d;
    logic [3:0]        tens_q,   tens_d;
    logic [3:0]        hunds_q,  hunds_d;
    logic              done_q,   done_d;
    logic [CNT_W-1:0]  ref_q,    ref_d;
    logic [2:0]        sel_q,    sel_d;
    logic [6:0]        seg_q,    seg_d;

    logic              xfer;
    logic [19:0]       bcd_adj;
    logic              ref_tc;
    logic [3:0]        digit_sel;
    logic              blank_sel;

    assign o_ready    = (state_q == ST_IDLE) || (state_q == ST_SHOW);
    assign o_busy     = (state_q == ST_MUL)  || (state_q == ST_BCD);
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_seg      = seg_q;
    assign o_digit_en = sel_q;

    assign xfer = i_valid && o_ready;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        bcd_d    = bcd_q;
        result_d = result_q;
        units_d  = units_q;
        tens_d   = tens_q;
        hunds_d  = hunds_q;
        done_d   = 1'b0;
        bcd_adj  = bcd_q;

        case (state_q)
            ST_IDLE, ST_SHOW: begin
                if (xfer) begin
                    state_d  = ST_MUL;
                    step_d   = 3'd0;
                    mcand_d  = {4'b0000, i_a};
                    mplier_d = i_b;
                    prod_d   = 8'd0;
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 3'd1;
                if (step_q == 3'd3) begin
                    // Seed the converter with the product completed on this edge.
                    state_d = ST_BCD;
                    step_d  = 3'd0;
                    bcd_d   = {12'd0, prod_d};
                end
            end
            ST_BCD: begin
                bcd_adj = {add3_ge5(bcd_q[19:16]), add3_ge5(bcd_q[15:12]),
                           add3_ge5(bcd_q[11:8]),  bcd_q[7:0]};
                bcd_d   = bcd_adj << 1;
                step_d  = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d  = ST_SHOW;
                    step_d   = 3'd0;
                    result_d = prod_q;
                    hunds_d  = bcd_d[19:16];
                    tens_d   = bcd_d[15:12];
                    units_d  = bcd_d[11:8];
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Segment register is loaded from the next-cycle digit select and digit
    // values so o_seg and o_digit_en always change together.
    always_comb begin
        ref_tc    = (ref_q == REF_TC);
        ref_d     = ref_tc ? '0 : ref_q + CNT_W'(1);
        sel_d     = ref_tc ? {sel_q[1:0], sel_q[2]} : sel_q;
        digit_sel = units_d;
        blank_sel = 1'b0;
        case (sel_d)
            3'b010: begin
                digit_sel = tens_d;
`ifdef LEADING_ZERO_BLANK_EN
                blank_sel = (tens_d == 4'd0) && (hunds_d == 4'd0);
`endif
            end
            3'b100: begin
                digit_sel = hunds_d;
`ifdef LEADING_ZERO_BLANK_EN
                blank_sel = (hunds_d == 4'd0);
`endif
            end
            default: begin
                digit_sel = units_d;
            end
        endcase
        seg_d = blank_sel ? 7'b0000000 : seg_of(digit_sel);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= 3'd0;
            mcand_q  <= 8'd0;
            mplier_q <= 4'd0;
            prod_q   <= 8'd0;
            bcd_q    <= 20'd0;
            result_q <= 8'd0;
            units_q  <= 4'd0;
            tens_q   <= 4'd0;
            hunds_q  <= 4'd0;
            done_q   <= 1'b0;
            ref_q    <= '0;
            sel_q    <= 3'b001;
            seg_q    <= 7'b0111111;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            bcd_q    <= bcd_d;
            result_q <= result_d;
            units_q  <= units_d;
            tens_q   <= tens_d;
            hunds_q  <= hunds_d;
            done_q   <= done_d;
            ref_q    <= ref_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
        end
    end

endmodule

// File: tb/tb_mult_display_ctrl.sv
// Self-checking bench for mult_display_ctrl with a behavioural model of the
// operand handshake, result latency and display scan.
module tb_mult_display_ctrl;

    localparam int DIV = 4;
    localparam logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011,
                                        7'b1001111, 7'b1100110, 7'b1101101,
                                        7'b1111101, 7'b0000111, 7'b1111111,
                                        7'b1101111};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       o_ready, o_busy, o_done;
    logic [7:0] o_result;
    logic [6:0] o_seg;
    logic [2:0] o_digit_en;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int m_left   = 0;   // busy cycles still to go
    int m_pa     = 0;
    int m_pb     = 0;
    int m_result = 0;
    int m_done   = 0;
    int m_tick   = 0;
    int m_digit  = 0;   // 0 units, 1 tens, 2 hunds

    always #5 clk = ~clk;

    mult_display_ctrl #(.REFRESH_DIV(DIV)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_a        (a),
        .i_b        (b),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_seg      (o_seg),
        .o_digit_en (o_digit_en)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_seg();
        int  d;
        bit  blank;
        blank = 1'b0;
        case (m_digit)
            0: d = m_result % 10;
            1: begin
                d = (m_result / 10) % 10;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (m_result < 10);
`endif
            end
            default: begin
                d = m_result / 100;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (m_result < 100);
`endif
            end
        endcase
        return blank ? 0 : int'(PAT[d]);
    endfunction

    task automatic model_reset();
        m_left = 0; m_result = 0; m_done = 0; m_tick = 0; m_digit = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_result = m_pa * m_pb;
                m_done   = 1;
            end
        end else if (valid) begin
            m_pa   = int'(a);
            m_pb   = int'(b);
            m_left = 12;
        end
        if (m_tick == DIV - 1) begin
            m_tick  = 0;
            m_digit = (m_digit + 1) % 3;
        end else begin
            m_tick++;
        end
    endtask

    always @(negedge clk) begin
        check("ready",    int'(o_ready),    int'(m_left == 0));
        check("busy",     int'(o_busy),     int'(m_left != 0));
        check("done",     int'(o_done),     m_done);
        check("result",   int'(o_result),   m_result);
        check("digit_en", int'(o_digit_en), 1 << m_digit);
        check("seg",      int'(o_seg),      exp_seg());
    end

    // One clock: drive after the falling edge, step the model on the rising
    // edge, return shortly after it so outputs have settled.
    task automatic cycle(input bit v, input logic [3:0] ai, input logic [3:0] bi);
        @(negedge clk);
        #1;
        valid = v; a = ai; b = bi;
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic pulse_reset(input int hold, input bit v, input logic [3:0] ai,
                               input logic [3:0] bi);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        model_reset();
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #2;
        valid = v; a = ai; b = bi;
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic wait_done(input bit v, input logic [3:0] ai, input logic [3:0] bi,
                             output int lat, output int nbusy);
        lat = 1;
        nbusy = 0;
        while (!o_done && lat < 30) begin
            if (o_busy) nbusy++;
            cycle(v, ai, bi);
            lat++;
        end
        check("done_seen", int'(o_done), 1);
    endtask

    task automatic capture(output logic [6:0] su, output logic [6:0] st,
                           output logic [6:0] sh);
        su = 7'b1000000; st = 7'b1000000; sh = 7'b1000000;
        for (int i = 0; i < 3 * DIV; i++) begin
            case (o_digit_en)
                3'b001:  su = o_seg;
                3'b010:  st = o_seg;
                3'b100:  sh = o_seg;
                default: ;
            endcase
            cycle(1'b0, 4'd0, 4'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nbusy, ndone, last_change;
        logic [6:0] su, st, sh;
        logic [2:0] en_hist [25];
        logic [2:0] prev;

        model_reset();
        pulse_reset(2, 1'b0, 4'd0, 4'd0);
        check("rst_digit_en", int'(o_digit_en), 1);
        check("rst_seg",      int'(o_seg), int'(7'b0111111));
        check("rst_result",   int'(o_result), 0);
        check("rst_ready",    int'(o_ready), 1);

        // 15*15
        cycle(1'b1, 4'd15, 4'd15);
        wait_done(1'b0, 4'd0, 4'd0, lat, nbusy);
        check("lat_15x15",  lat, 13);
        check("busy_15x15", nbusy, 12);
        check("res_15x15",  int'(o_result), 225);
        capture(su, st, sh);
        check("seg_u_225", int'(su), int'(7'b1101101));
        check("seg_t_225", int'(st), int'(7'b1011011));
        check("seg_h_225", int'(sh), int'(7'b1011011));

        // 0*9
        cycle(1'b1, 4'd0, 4'd9);
        wait_done(1'b0, 4'd0, 4'd0, lat, nbusy);
        check("res_0x9", int'(o_result), 0);
        capture(su, st, sh);
        check("seg_u_0", int'(su), int'(7'b0111111));
`ifdef LEADING_ZERO_BLANK_EN
        check("seg_t_0", int'(st), 0);
        check("seg_h_0", int'(sh), 0);
`else
        check("seg_t_0", int'(st), int'(7'b0111111));
        check("seg_h_0", int'(sh), int'(7'b0111111));
`endif

        // 7*6 with 1*1 held on i_valid through busy, accepted in the done cycle
        cycle(1'b1, 4'd7, 4'd6);
        wait_done(1'b1, 4'd1, 4'd1, lat, nbusy);
        check("lat_7x6", lat, 13);
        check("res_7x6", int'(o_result), 42);
        cycle(1'b1, 4'd1, 4'd1);
        check("busy_after_accept", int'(o_busy), 1);
        wait_done(1'b0, 4'd0, 4'd0, lat, nbusy);
        check("res_1x1", int'(o_result), 1);

        // reset in cycle 6 of 12*11
        cycle(1'b1, 4'd12, 4'd11);
        repeat (5) cycle(1'b0, 4'd0, 4'd0);
        pulse_reset(2, 1'b0, 4'd0, 4'd0);
        check("abort_result", int'(o_result), 0);
        check("abort_ready",  int'(o_ready), 1);
        ndone = 0;
        repeat (15) begin
            cycle(1'b0, 4'd0, 4'd0);
            if (o_done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // reset during MUL, operand pair offered on the first edge after release
        cycle(1'b1, 4'd9, 4'd9);
        repeat (3) cycle(1'b0, 4'd0, 4'd0);
        pulse_reset(1, 1'b1, 4'd3, 4'd5);
        check("first_edge_accept", int'(o_busy), 1);
        wait_done(1'b0, 4'd0, 4'd0, lat, nbusy);
        check("res_3x5", int'(o_result), 15);

        // 13*9 = 117 scan order and dwell
        cycle(1'b1, 4'd13, 4'd9);
        wait_done(1'b0, 4'd0, 4'd0, lat, nbusy);
        check("res_13x9", int'(o_result), 117);
        for (int i = 0; i < 25; i++) begin
            en_hist[i] = o_digit_en;
            cycle(1'b0, 4'd0, 4'd0);
        end
        last_change = -1;
        for (int i = 1; i < 25; i++) begin
            if (en_hist[i] != en_hist[i-1]) begin
                prev = en_hist[i-1];
                check("scan_order", int'(en_hist[i]), int'({prev[1:0], prev[2]}));
                if (last_change >= 0) check("scan_dwell", i - last_change, DIV);
                last_change = i;
            end
        end
        capture(su, st, sh);
        check("seg_u_117", int'(su), int'(7'b0000111));
        check("seg_t_117", int'(st), int'(7'b0000110));
        check("seg_h_117", int'(sh), int'(7'b0000110));

        // randomized traffic with occasional resets
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) == 0)
                pulse_reset(int'($urandom_range(1, 2)), $urandom_range(0, 1) == 1,
                            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            else
                cycle($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
